ysyx_220066_trap_ctrl: RTL

YSYX_220066_TRAP_CTRL -- requirements
Module: ysyx_220066_trap_ctrl

---
 rtl/ysyx_220066_pkg.sv | 30 +++
 rtl/ysyx_220066_mstatus_upd.sv | 23 ++
 rtl/ysyx_220066_trap_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/ysyx_220066_pkg.sv
// Shared definitions for the trap controller: FSM states, CSR addresses,
// trap cause codes and mstatus bit positions.
package ysyx_220066_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SAVE_EPC   = 3'd1,
    ST_SAVE_CAUSE = 3'd2,
    ST_UPD_STATUS = 3'd3,
    ST_RESTORE    = 3'd4,
    ST_REDIRECT   = 3'd5,
    ST_HALT       = 3'd6
  } trap_state_t;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [63:0] CAUSE_ERROR = 64'd2;
  localparam logic [63:0] CAUSE_ECALL = 64'd11;
  localparam logic [63:0] CAUSE_IRQ   = 64'h8000_0000_0000_0007;

  localparam int MS_MIE     = 3;
  localparam int MS_MPIE    = 7;
  localparam int MS_MPP_LO  = 11;
  localparam int MS_MPP_HI  = 12;

  localparam logic [1:0] PRIV_M = 2'b11;

endpackage

// File: rtl/ysyx_220066_mstatus_upd.sv
// Combinational mstatus rewrites for trap entry and for mret; both variants
// are derived from the same source value and the caller picks one.
module ysyx_220066_mstatus_upd
  import ysyx_220066_pkg::*;
(
  input  logic [63:0] i_mstatus,
  output logic [63:0] o_trap,
  output logic [63:0] o_mret
);

  always_comb begin
    o_trap                       = i_mstatus;
    o_trap[MS_MPIE]              = i_mstatus[MS_MIE];
    o_trap[MS_MIE]               = 1'b0;
    o_trap[MS_MPP_HI:MS_MPP_LO]  = PRIV_M;

    o_mret                       = i_mstatus;
    o_mret[MS_MIE]               = i_mstatus[MS_MPIE];
    o_mret[MS_MPIE]              = 1'b1;
    o_mret[MS_MPP_HI:MS_MPP_LO]  = PRIV_M;
  end

endmodule

// File: rtl/ysyx_220066_trap_ctrl.sv
// Trap controller FSM: sequences mepc/mcause/mstatus writes, mret restore,
// fetch redirect and simulation halt. Define YSYX_220066_TRAP_IRQ_EN to add
// the external interrupt input (irq) and its acknowledge (irq_ack).
module ysyx_220066_trap_ctrl
  import ysyx_220066_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
`ifdef YSYX_220066_TRAP_IRQ_EN
  input  logic        irq,
  output logic        irq_ack,
`endif
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] pc,
  input  logic        ecall,
  input  logic        mret,
  input  logic        error,
  input  logic        done,
  input  logic [63:0] mtvec,
  input  logic [63:0] mepc,
  input  logic [63:0] mstatus,
  output logic        csr_wen,
  output logic [11:0] csr_waddr,
  output logic [63:0] csr_wdata,
  output logic        flush,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc,
  output logic        halt,
  output logic        busy
);

  trap_state_t r_state;
  logic [63:0] r_pc;
  logic [63:0] r_mstatus;
  logic [63:0] r_cause;
  logic        r_is_mret;
  logic        r_csr_wen;
  logic [11:0] r_csr_waddr;
  logic [63:0] r_csr_wdata;
  logic        r_flush;
  logic        r_redirect_valid;
  logic        r_halt;

  logic [63:0] w_ms_src;
  logic [63:0] w_ms_trap;
  logic [63:0] w_ms_mret;
  logic        w_take_irq;
  logic        w_take_trap;
  logic [63:0] w_cause;
  logic        w_unused;

`ifdef YSYX_220066_TRAP_IRQ_EN
  logic        r_is_irq;
  logic        r_irq_ack;
  // Interrupt is only taken when globally enabled at the moment of transfer.
  assign w_take_irq = irq & mstatus[MS_MIE];
  assign irq_ack    = r_irq_ack;
`else
  assign w_take_irq = 1'b0;
`endif

  assign w_take_trap = w_take_irq | error | ecall;
  assign w_cause     = w_take_irq ? CAUSE_IRQ :
                       error      ? CAUSE_ERROR : CAUSE_ECALL;

  // In IDLE the mret variant must see the live value; later the trap variant uses the latch.
  assign w_ms_src = (r_state == ST_IDLE) ? mstatus : r_mstatus;

  ysyx_220066_mstatus_upd u_mstatus_upd (
    .i_mstatus (w_ms_src),
    .o_trap    (w_ms_trap),
    .o_mret    (w_ms_mret)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= ST_IDLE;
      r_pc             <= '0;
      r_mstatus        <= '0;
      r_cause          <= '0;
      r_is_mret        <= 1'b0;
      r_csr_wen        <= 1'b0;
      r_csr_waddr      <= '0;
      r_csr_wdata      <= '0;
      r_flush          <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_halt           <= 1'b0;
`ifdef YSYX_220066_TRAP_IRQ_EN
      r_is_irq         <= 1'b0;
      r_irq_ack        <= 1'b0;
`endif
    end else begin
      r_csr_wen        <= 1'b0;
      r_csr_waddr      <= '0;
      r_csr_wdata      <= '0;
      r_flush          <= 1'b0;
      r_redirect_valid <= 1'b0;
`ifdef YSYX_220066_TRAP_IRQ_EN
      r_irq_ack        <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            if (w_take_trap) begin
              r_pc        <= pc;
              r_mstatus   <= mstatus;
              r_cause     <= w_cause;
              r_is_mret   <= 1'b0;
`ifdef YSYX_220066_TRAP_IRQ_EN
              r_is_irq    <= w_take_irq;
`endif
              r_flush     <= 1'b1;
              r_csr_wen   <= 1'b1;
              r_csr_waddr <= CSR_MEPC;
              r_csr_wdata <= pc;
              r_state     <= ST_SAVE_EPC;
            end else if (mret) begin
              r_mstatus   <= mstatus;
              r_is_mret   <= 1'b1;
`ifdef YSYX_220066_TRAP_IRQ_EN
              r_is_irq    <= 1'b0;
`endif
              r_flush     <= 1'b1;
              r_csr_wen   <= 1'b1;
              r_csr_waddr <= CSR_MSTATUS;
              r_csr_wdata <= w_ms_mret;
              r_state     <= ST_RESTORE;
            end else if (done) begin
              r_flush     <= 1'b1;
              r_halt      <= 1'b1;
              r_state     <= ST_HALT;
            end
          end
        end
        ST_SAVE_EPC: begin
          r_csr_wen   <= 1'b1;
          r_csr_waddr <= CSR_MCAUSE;
          r_csr_wdata <= r_cause;
          r_state     <= ST_SAVE_CAUSE;
        end
        ST_SAVE_CAUSE: begin
          r_csr_wen   <= 1'b1;
          r_csr_waddr <= CSR_MSTATUS;
          r_csr_wdata <= w_ms_trap;
          r_state     <= ST_UPD_STATUS;
        end
        ST_UPD_STATUS: begin
          r_redirect_valid <= 1'b1;
`ifdef YSYX_220066_TRAP_IRQ_EN
          r_irq_ack        <= r_is_irq;
`endif
          r_state          <= ST_REDIRECT;
        end
        ST_RESTORE: begin
          r_redirect_valid <= 1'b1;
          r_state          <= ST_REDIRECT;
        end
        ST_REDIRECT: begin
          r_state <= ST_IDLE;
        end
        ST_HALT: begin
          r_state <= ST_HALT;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready       = (r_state == ST_IDLE);
  assign busy           = (r_state != ST_IDLE);
  assign csr_wen        = r_csr_wen;
  assign csr_waddr      = r_csr_waddr;
  assign csr_wdata      = r_csr_wdata;
  assign flush          = r_flush;
  assign redirect_valid = r_redirect_valid;
  assign halt           = r_halt;

  // Redirect target follows the live CSR inputs during the REDIRECT cycle.
  assign redirect_pc = (r_state != ST_REDIRECT) ? 64'd0 :
                       r_is_mret                ? mepc  : {mtvec[63:2], 2'b00};

  assign w_unused = ^mtvec[1:0];

endmodule
